// File: rtl/bldc_cmd_scheduler.sv
// bldc_cmd_scheduler: slew-limited per-motor duty scheduler with sticky fault latching and a command watchdog
module bldc_cmd_scheduler #(
  parameter int NUM_MOTORS       = 5,
  parameter int DUTY_CYCLE_WIDTH = 10,
  parameter int MAX_DUTY_CYCLE   = 'h3FF,
  parameter int SLEW_STEP        = 8,
  parameter int SLEW_PERIOD      = 1024,
  parameter int WATCHDOG_CYCLES  = 2**20
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [2:0]                             wr_addr,
  input  logic [DUTY_CYCLE_WIDTH-1:0]            wr_data,
  input  logic [NUM_MOTORS-1:0]                  fault_in,
  output logic [NUM_MOTORS*DUTY_CYCLE_WIDTH-1:0] duty_out,
  output logic [NUM_MOTORS-1:0]                  en_out,
  output logic [NUM_MOTORS-1:0]                  fault_latched,
  output logic                                   wd_expired
);
  localparam int W  = DUTY_CYCLE_WIDTH;
  localparam int TW = $clog2(SLEW_PERIOD);
  localparam int WW = $clog2(WATCHDOG_CYCLES);
  localparam int IW = NUM_MOTORS > 1 ? $clog2(NUM_MOTORS) : 1;
  localparam logic [W:0]    MAXV      = MAX_DUTY_CYCLE[W:0];
  localparam logic [W:0]    STEPV     = SLEW_STEP[W:0];
  localparam logic [TW-1:0] TICK_LAST = TW'(SLEW_PERIOD - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [WW-1:0] WD_PRE    = WW'(WATCHDOG_CYCLES - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_MOTORS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         rdy_q, rdy_d;
  logic [TW-1:0]                tick_q, tick_d;
  logic [WW-1:0]                wd_q, wd_d;
  logic                         wdx_q, wdx_d;
  logic [NUM_MOTORS-1:0][W-1:0] tgt_q, tgt_d;
  logic [NUM_MOTORS-1:0][W-1:0] cur_q, cur_d;
  logic [NUM_MOTORS-1:0]        fl_q, fl_d;
  logic [NUM_MOTORS-1:0]        en_q, en_d;
  logic                         tick, acc, wr_motor, wr_clr, restart, expire;
  logic [W-1:0]                 wr_clamped;

  // Move c toward t by at most one step, computed one bit wider so it cannot wrap or overshoot
  function automatic logic [W-1:0] slew(input logic [W-1:0] c, input logic [W-1:0] t);
    logic [W:0] up, dn;
    up = {1'b0, t} - {1'b0, c};
    dn = {1'b0, c} - {1'b0, t};
    return c < t ? W'({1'b0, c} + (up > STEPV ? STEPV : up)) :
           c > t ? W'({1'b0, c} - (dn > STEPV ? STEPV : dn)) : c;
  endfunction

  assign tick       = tick_q == TICK_LAST;
  assign acc        = wr_valid & rdy_q;
  assign wr_motor   = acc && int'(wr_addr) < NUM_MOTORS;
  assign wr_clr     = acc && wr_addr == 3'd7;
  assign restart    = wr_motor | wr_clr;
  assign expire     = !restart && wd_q == WD_PRE;
  assign wr_clamped = ({1'b0, wr_data} > MAXV) ? MAXV[W-1:0] : wr_data;

  // Scan FSM state and visit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Enter a scan on each tick, leave after the last motor has been visited
  always_comb begin
    state_d = state_q == IDLE ? (tick ? SCAN : IDLE) : (idx_q == IDX_LAST ? IDLE : SCAN);
    idx_d   = state_q == SCAN ? idx_q + 1'b1 : '0;
  end

  // Ready is registered from the next state so it is low throughout reset and the scan
  always_comb begin
    rdy_d = state_d == IDLE;
  end

  // Datapath registers: counters, targets, applied duties, fault and enable status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q  <= 1'b0;
      tick_q <= '0;
      wd_q   <= '0;
      wdx_q  <= 1'b0;
      tgt_q  <= '0;
      cur_q  <= '0;
      fl_q   <= '0;
      en_q   <= '0;
    end else begin
      rdy_q  <= rdy_d;
      tick_q <= tick_d;
      wd_q   <= wd_d;
      wdx_q  <= wdx_d;
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      fl_q   <= fl_d;
      en_q   <= en_d;
    end
  end

  // Faults and watchdog expiry override writes and slewing; enables fall at once but rise a clock late
  always_comb begin
    tick_d = tick ? '0 : tick_q + 1'b1;
    wd_d   = restart ? '0 : (wd_q == WD_LAST ? wd_q : wd_q + 1'b1);
    wdx_d  = restart ? 1'b0 : (wdx_q | expire);
    fl_d   = (fl_q & ~(wr_clr ? wr_data[NUM_MOTORS-1:0] : '0)) | fault_in;
    tgt_d  = tgt_q;
    cur_d  = cur_q;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      tgt_d[i] = (fault_in[i] || expire) ? '0 :
                 (wr_motor && int'(wr_addr) == i && !fl_q[i]) ? wr_clamped : tgt_q[i];
      cur_d[i] = (fault_in[i] || expire) ? '0 :
                 (state_q == SCAN && int'(idx_q) == i) ? slew(cur_q[i], tgt_q[i]) : cur_q[i];
    end
    en_d = ~fl_d & ~fl_q & ~{NUM_MOTORS{wdx_d | wdx_q}};
  end

  assign wr_ready      = rdy_q;
  assign duty_out      = cur_q;
  assign en_out        = en_q;
  assign fault_latched = fl_q;
  assign wd_expired    = wdx_q;
endmodule

// File: tb/tb_bldc_cmd_scheduler.sv
// tb_bldc_cmd_scheduler: directed stimulus checked every cycle against a time-indexed behavioural model
module tb_bldc_cmd_scheduler;
  localparam int N = 5, W = 10, P = 16, WD = 64, STEP = 8, MAXD = 'h3FF;

  logic           clk = 0, rst = 1, wr_valid = 0, wr_ready;
  logic [2:0]     wr_addr = 0;
  logic [W-1:0]   wr_data = 0;
  logic [N-1:0]   fault_in = 0, en_out, fault_latched;
  logic [N*W-1:0] duty_out;
  logic           wd_expired;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int n, low, acc0, t0;

  bldc_cmd_scheduler #(
    .NUM_MOTORS(N), .DUTY_CYCLE_WIDTH(W), .MAX_DUTY_CYCLE(MAXD),
    .SLEW_STEP(STEP), .SLEW_PERIOD(P), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .fault_in(fault_in),
    .duty_out(duty_out), .en_out(en_out), .fault_latched(fault_latched),
    .wd_expired(wd_expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] duty(input int i);
    return 32'(duty_out[i*W +: W]);
  endfunction

  // Model: k counts clocks since reset; scan phase and ready follow from k by plain arithmetic
  int      k, last_r, j, diff, a, d;
  int      m_tgt[N], m_cur[N];
  bit [N-1:0] m_fl, m_en, fl_old;
  bit      m_wdx, m_rdy, wdx_old, m_acc, restart, expire;

  function automatic bit ready_at(input int e);
    return e >= 1 && !(e >= P && e % P < N);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; last_r = 0; m_fl = '0; m_en = '0; m_wdx = 0; m_rdy = 0;
      for (int i = 0; i < N; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
    end else begin
      m_acc = wr_valid && ready_at(k);
      a = int'(wr_addr);
      d = int'(wr_data);
      restart = m_acc && (a < N || a == 7);
      expire = !restart && (k + 1 - last_r == WD - 1);
      fl_old = m_fl;
      wdx_old = m_wdx;
      if (k >= P && k % P < N) begin
        j = k % P;
        diff = m_tgt[j] - m_cur[j];
        m_cur[j] += diff > STEP ? STEP : (diff < -STEP ? -STEP : diff);
      end
      if (m_acc && a < N && !fl_old[a] && !fault_in[a]) m_tgt[a] = d > MAXD ? MAXD : d;
      if (m_acc && a == 7) m_fl &= ~wr_data[N-1:0];
      if (restart) begin last_r = k + 1; m_wdx = 0; end
      if (expire) begin
        m_wdx = 1;
        for (int i = 0; i < N; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
      end
      for (int i = 0; i < N; i++)
        if (fault_in[i]) begin m_fl[i] = 1; m_tgt[i] = 0; m_cur[i] = 0; end
      m_en = ~(m_fl | fl_old | {N{m_wdx | wdx_old}});
      k++;
      m_rdy = ready_at(k);
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("m_wr_ready", 32'(wr_ready), 32'(m_rdy));
    for (int i = 0; i < N; i++) chk($sformatf("m_duty%0d", i), duty(i), 32'(m_cur[i]));
    chk("m_en_out", 32'(en_out), 32'(m_en));
    chk("m_fault_latched", 32'(fault_latched), 32'(m_fl));
    chk("m_wd_expired", 32'(wd_expired), 32'(m_wdx));
  end

  always @(posedge clk) begin
    cyc++;
    if (wr_valid && wr_ready) acc_cnt++;
  end

  // Called on a falling edge; holds the request until it is accepted
  task automatic wr(input logic [2:0] ad, input logic [W-1:0] dt);
    int c = 0;
    wr_valid = 1; wr_addr = ad; wr_data = dt;
    while (!wr_ready && c < 50) begin @(negedge clk); c++; end
    chk("wr_accept_timeout", 32'(c < 50), 1);
    @(negedge clk);
    wr_valid = 0;
    acc_cyc = cyc;
  endtask

  // Returns on the first falling edge after a scan has completed
  task automatic next_tick(input bit keepalive);
    int c = 0;
    while (wr_ready && c < 100) begin @(negedge clk); c++; end
    while (!wr_ready && c < 100) begin @(negedge clk); c++; end
    chk("tick_timeout", 32'(c < 100), 1);
    if (keepalive) wr(7, 0);
  endtask

  int ramp2[13] = '{8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88, 96, 100};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(wr_ready), 0);
    chk("rst_en", 32'(en_out), 0);
    chk("rst_duty", 32'(duty_out == 0), 1);
    chk("rst_fl", 32'(fault_latched), 0);
    chk("rst_wdx", 32'(wd_expired), 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(wr_ready), 1);
    chk("post_rst_en", 32'(en_out), 32'h1F);

    wr(2, 100);
    for (int t = 0; t < 13; t++) begin
      next_tick(1);
      chk($sformatf("ramp2_%0d", t), duty(2), 32'(ramp2[t]));
      chk("others_zero", 32'(duty(0) | duty(1) | duty(3) | duty(4)), 0);
    end

    wr(0, 'h3FF);
    for (int t = 1; t <= 5; t++) begin next_tick(1); chk("rise0", duty(0), 32'(8 * t)); end
    wr(0, 0);
    for (int t = 4; t >= 0; t--) begin next_tick(1); chk("fall0", duty(0), 32'(8 * t)); end
    wr(4, 5);
    next_tick(1);
    chk("no_overshoot4", duty(4), 5);

    wr(1, 64);
    for (int t = 0; t < 8; t++) next_tick(1);
    chk("m1_at_64", duty(1), 64);
    fault_in = 5'b00010;
    @(negedge clk);
    fault_in = 0;
    chk("fault_duty1", duty(1), 0);
    chk("fault_en", 32'(en_out), 32'h1D);
    chk("fault_fl1", 32'(fault_latched[1]), 1);
    wr(1, 50);
    next_tick(1);
    chk("latched_write_ignored", duty(1), 0);
    wr(7, 10'b00010);
    chk("clear_fl", 32'(fault_latched), 0);
    chk("clear_en_still_low", 32'(en_out[1]), 0);
    @(negedge clk);
    chk("clear_en_rises", 32'(en_out[1]), 1);

    n = 0;
    while (wr_ready && n < 40) begin @(negedge clk); n++; end
    acc0 = acc_cnt;
    wr_valid = 1; wr_addr = 3; wr_data = 77;
    low = 0;
    while (!wr_ready && n < 80) begin low++; @(negedge clk); n++; end
    chk("ready_low_len", 32'(low), 5);
    @(negedge clk);
    wr_valid = 0;
    chk("accept_once", 32'(acc_cnt - acc0), 1);
    next_tick(1);
    chk("held_write_applied", duty(3), 8);

    wr(3, 50);
    t0 = acc_cyc;
    wr(6, 'h155);
    while (cyc < t0 + 62) @(negedge clk);
    chk("wd_not_yet", 32'(wd_expired), 0);
    @(negedge clk);
    chk("wd_expired", 32'(wd_expired), 1);
    chk("wd_duty_zero", 32'(duty_out == 0), 1);
    chk("wd_en_zero", 32'(en_out), 0);
    wr(3, 10);
    chk("wd_cleared", 32'(wd_expired), 0);
    chk("wd_en_low_one_more", 32'(en_out), 0);
    @(negedge clk);
    chk("wd_en_back", 32'(en_out), 32'h1F);

    next_tick(1);
    chk("pre_rst_duty3", duty(3), 8);
    n = 0;
    while (wr_ready && n < 40) begin @(negedge clk); n++; end
    #2 rst = 1;
    #1;
    chk("async_duty", 32'(duty_out == 0), 1);
    chk("async_en", 32'(en_out), 0);
    chk("async_ready", 32'(wr_ready), 0);
    chk("async_fl", 32'(fault_latched), 0);
    chk("async_wdx", 32'(wd_expired), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rerst_ready", 32'(wr_ready), 1);
    chk("rerst_en", 32'(en_out), 32'h1F);
    chk("rerst_duty", 32'(duty_out == 0), 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
